// File: rtl/dmem_pkg.sv
// Shared types, constants and lane helpers for the banked data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RESP   = 2'd1,
    ST_P_WAIT = 2'd2
  } state_e;

  // Which source supplies load data in RESP
  typedef enum logic [1:0] {
    SRC_RAM    = 2'd0,
    SRC_STACK  = 2'd1,
    SRC_PERIPH = 2'd2
  } src_e;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  localparam logic [19:0] REGION_RAM    = 20'h00000;
  localparam logic [19:0] REGION_STACK  = 20'h3FFFF;
  localparam logic [19:0] REGION_PERIPH = 20'h40000;

  // Words addressable by addr[11:2] inside one 4 KiB region
  localparam int REGION_WORDS = 1024;

  // Byte enables for a (size, byte offset) pair
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return 4'b0001 << off;
      SIZE_HALF: return 4'b0011 << off;
      default:   return 4'b1111;
    endcase
  endfunction

  // Replicate right-justified store data so every possible lane carries it
  function automatic logic [31:0] lane_align(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SIZE_BYTE: return {4{data[7:0]}};
      SIZE_HALF: return {2{data[15:0]}};
      default:   return data;
    endcase
  endfunction

  // Pull the addressed lanes down to bit 0 and zero-extend
  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off);
    logic [31:0] shifted;
    shifted = word >> {off, 3'b000};
    case (size)
      SIZE_BYTE: return {24'd0, shifted[7:0]};
      SIZE_HALF: return {16'd0, shifted[15:0]};
      default:   return shifted;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// One byte-lane-enabled word array with registered read and asynchronous clear.
// BASE is the region word index that maps onto local word 0.
module dmem_bank #(
  parameter int DEPTH = 256,
  parameter int BASE  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [9:0]  idx,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] local_addr;

  assign local_addr = AW'(idx - 10'(BASE));

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_q [DEPTH];
      logic [7:0] rd_q;

      // Per-lane storage: cleared on reset, written when this lane is enabled
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) lane_q[i] <= 8'd0;
        end else if (en && we && be[gi]) begin
          lane_q[local_addr] <= wdata[8*gi +: 8];
        end
      end

      // Registered read of the whole word; the top picks lanes afterwards
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_q <= 8'd0;
        end else if (en && !we) begin
          rd_q <= lane_q[local_addr];
        end
      end

      assign rdata[8*gi +: 8] = rd_q;
    end
  endgenerate

endmodule

// File: rtl/banked_data_mem.sv
// CPU data memory: RAM bank, top-aligned stack bank and a peripheral port
// with timeout. One access in flight; each completes with a one-cycle ready.
module banked_data_mem
  import dmem_pkg::*;
#(
  parameter int RAM_WORDS      = 256,
  parameter int STACK_WORDS    = 64,
  parameter int PERIPH_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        fault,
  output logic        busy,
  output logic        p_req,
  output logic        p_we,
  output logic [31:0] p_addr,
  output logic [31:0] p_wdata,
  output logic [3:0]  p_be,
  input  logic [31:0] p_rdata,
  input  logic        p_ack
);

  localparam int CNT_W = $clog2(PERIPH_TIMEOUT + 1);
  localparam int STACK_BASE = REGION_WORDS - STACK_WORDS;

  state_e      state_q, state_d;
  src_e        src_q, src_d;
  logic        fault_q, fault_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        p_we_q, p_we_d;
  logic [31:0] p_addr_q, p_addr_d;
  logic [31:0] p_wdata_q, p_wdata_d;
  logic [3:0]  p_be_q, p_be_d;
  logic [31:0] p_rdata_q, p_rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [19:0] region;
  logic [9:0]  word_idx;
  logic        ram_hit, stack_hit, periph_hit, aligned, acc_fault, accept;
  logic [3:0]  acc_be;
  logic [31:0] acc_wdata;
  logic [31:0] ram_rdata, stack_rdata, src_word;

  assign region    = addr[31:12];
  assign word_idx  = addr[11:2];
  assign ram_hit   = (region == REGION_RAM) && ({22'd0, word_idx} < 32'(RAM_WORDS));
  assign stack_hit = (region == REGION_STACK) && ({22'd0, word_idx} >= 32'(STACK_BASE));
  assign periph_hit = (region == REGION_PERIPH);
  assign aligned   = (size == SIZE_BYTE) ||
                     ((size == SIZE_HALF) && !addr[0]) ||
                     ((size == SIZE_WORD) && (addr[1:0] == 2'b00));
  assign acc_fault = !aligned || !(ram_hit || stack_hit || periph_hit);
  assign accept    = (state_q == ST_IDLE) && req;
  assign acc_be    = byte_en(size, addr[1:0]);
  assign acc_wdata = lane_align(size, wdata);

  dmem_bank #(.DEPTH(RAM_WORDS), .BASE(0)) u_ram (
    .clk   (clk),
    .rst_n (reset),
    .en    (accept && ram_hit && !acc_fault),
    .we    (we),
    .be    (acc_be),
    .idx   (word_idx),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  dmem_bank #(.DEPTH(STACK_WORDS), .BASE(STACK_BASE)) u_stack (
    .clk   (clk),
    .rst_n (reset),
    .en    (accept && stack_hit && !acc_fault),
    .we    (we),
    .be    (acc_be),
    .idx   (word_idx),
    .wdata (acc_wdata),
    .rdata (stack_rdata)
  );

  // Next-state logic: accept in IDLE, wait on the peripheral, then respond
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    fault_d   = fault_q;
    off_d     = off_q;
    size_d    = size_q;
    p_we_d    = p_we_q;
    p_addr_d  = p_addr_q;
    p_wdata_d = p_wdata_q;
    p_be_d    = p_be_q;
    p_rdata_d = p_rdata_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          off_d   = addr[1:0];
          size_d  = size;
          fault_d = acc_fault;
          src_d   = ram_hit ? SRC_RAM : (stack_hit ? SRC_STACK : SRC_PERIPH);
          if (!acc_fault && periph_hit) begin
            p_we_d    = we;
            p_addr_d  = addr;
            p_wdata_d = acc_wdata;
            p_be_d    = acc_be;
            cnt_d     = '0;
            state_d   = ST_P_WAIT;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_P_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // An ack on the final counted cycle still wins over the timeout
        if (p_ack) begin
          p_rdata_d = p_rdata;
          fault_d   = 1'b0;
          state_d   = ST_RESP;
        end else if (cnt_d == CNT_W'(PERIPH_TIMEOUT)) begin
          fault_d = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and access-context registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      src_q     <= SRC_RAM;
      fault_q   <= 1'b0;
      off_q     <= 2'b00;
      size_q    <= SIZE_BYTE;
      p_we_q    <= 1'b0;
      p_addr_q  <= 32'd0;
      p_wdata_q <= 32'd0;
      p_be_q    <= 4'd0;
      p_rdata_q <= 32'd0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      fault_q   <= fault_d;
      off_q     <= off_d;
      size_q    <= size_d;
      p_we_q    <= p_we_d;
      p_addr_q  <= p_addr_d;
      p_wdata_q <= p_wdata_d;
      p_be_q    <= p_be_d;
      p_rdata_q <= p_rdata_d;
      cnt_q     <= cnt_d;
    end
  end

  // Response data: selected lanes of the chosen source, zero on fault or outside RESP
  always_comb begin
    case (src_q)
      SRC_RAM:   src_word = ram_rdata;
      SRC_STACK: src_word = stack_rdata;
      default:   src_word = p_rdata_q;
    endcase
    rdata = 32'd0;
    if ((state_q == ST_RESP) && !fault_q) rdata = lane_extract(src_word, size_q, off_q);
  end

  assign ready   = (state_q == ST_RESP);
  assign fault   = (state_q == ST_RESP) && fault_q;
  assign busy    = (state_q != ST_IDLE);
  assign p_req   = (state_q == ST_P_WAIT);
  assign p_we    = p_req && p_we_q;
  assign p_be    = p_req ? p_be_q : 4'd0;
  assign p_addr  = p_addr_q;
  assign p_wdata = p_wdata_q;

endmodule

// File: tb/tb_banked_data_mem.sv
// Scoreboard bench for banked_data_mem: driver pushes expectations from a
// byte-level memory model, a monitor pops and compares on every ready.
module tb_banked_data_mem;

  localparam int RAM_WORDS   = 256;
  localparam int STACK_WORDS = 64;
  localparam int TMO         = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [31:0] rdata;
  logic        ready, fault, busy, p_req, p_we;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_be;
  logic [31:0] p_rdata = 32'd0;
  logic        p_ack = 1'b0;

  banked_data_mem #(.RAM_WORDS(RAM_WORDS), .STACK_WORDS(STACK_WORDS), .PERIPH_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .fault(fault), .busy(busy), .p_req(p_req), .p_we(p_we),
    .p_addr(p_addr), .p_wdata(p_wdata), .p_be(p_be), .p_rdata(p_rdata), .p_ack(p_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    bit          chk_rdata;
    logic [31:0] rdata;
    logic        fault;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  mem_m [logic [31:0]];
  int          n_vec = 0, n_miss = 0, n_txn = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every ready must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (reset && ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_ready", {31'd0, ready}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("fault", {31'd0, fault}, {31'd0, e.fault});
        if (e.chk_rdata) chk("rdata", rdata, e.rdata);
        $display("txn %0d: fault=%0b rdata=%h", e.id, fault, rdata);
      end
    end
  end

  function automatic bit is_mapped(input logic [31:0] a);
    int idx;
    idx = int'(a[11:2]);
    if (a[31:12] == 20'h00000) return idx < RAM_WORDS;
    if (a[31:12] == 20'h3FFFF) return idx >= 1024 - STACK_WORDS;
    return a[31:12] == 20'h40000;
  endfunction

  // One CPU access; ack_at = P_WAIT cycle on which p_ack is raised (0 = never)
  task automatic access(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input int ack_at, input logic [31:0] prd);
    int nb, off, lat, pcnt, exp_lat, exp_pcnt;
    bit flt, per, acked, done;
    logic [31:0] mask, val;
    exp_t e;
    @(negedge clk);
    for (int k = 0; k < 40 && busy; k++) @(negedge clk);
    req = 1'b1; we = w; size = sz; addr = a; wdata = wd;
    nb   = 1 << sz;
    off  = int'(a[1:0]);
    flt  = !((sz != 2'b11) && (off % nb == 0) && is_mapped(a));
    per  = !flt && (a[31:12] == 20'h40000);
    acked = (ack_at >= 1) && (ack_at <= TMO);
    mask = (nb >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    e.id = n_txn; n_txn++;
    e.chk_rdata = 1'b1; e.rdata = 32'd0; e.fault = flt;
    if (!flt && per) begin
      e.fault = !acked;
      if (w || !acked) e.chk_rdata = !w;
      else e.rdata = (prd >> (8 * off)) & mask;
    end else if (!flt) begin
      if (w) begin
        e.chk_rdata = 1'b0;
        for (int i = 0; i < nb; i++) mem_m[a + i] = wd[8*i +: 8];
      end else begin
        val = 32'd0;
        for (int i = 0; i < nb; i++)
          if (mem_m.exists(a + i)) val |= 32'(mem_m[a + i]) << (8 * i);
        e.rdata = val;
      end
    end
    sb_q.push_back(e);
    @(posedge clk); #1;
    // Keep req high with an illegal access while busy: it must be ignored
    we = 1'b0; size = 2'b11; addr = 32'h0; wdata = 32'hFFFF_FFFF;
    lat = 0; pcnt = 0; done = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      lat++;
      p_ack = 1'b0;
      if (p_req) begin
        pcnt++;
        if (pcnt == 1) begin
          chk("p_addr", p_addr, a);
          chk("p_we", {31'd0, p_we}, {31'd0, w});
          chk("p_be", {28'd0, p_be}, 32'((((1 << nb) - 1) << off) & 15));
          if (w) chk("p_wdata", (p_wdata >> (8 * off)) & mask, wd & mask);
        end
        if (pcnt == ack_at) begin p_ack = 1'b1; p_rdata = prd; end
      end
      if (ready) done = 1'b1;
    end
    if (!done) chk("ready_timeout", {31'd0, ready}, 32'd1);
    exp_pcnt = per ? (acked ? ack_at : TMO) : 0;
    exp_lat  = exp_pcnt + 1;
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("p_req_cycles", 32'(pcnt), 32'(exp_pcnt));
    @(negedge clk);
    req = 1'b0; p_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    logic [1:0]  rs;
    int          rk;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_busy",  {31'd0, busy},  32'd0);
    chk("rst_p_req", {31'd0, p_req}, 32'd0);
    chk("rst_p_we",  {31'd0, p_we},  32'd0);
    chk("rst_p_be",  {28'd0, p_be},  32'd0);
    chk("rst_rdata", rdata, 32'd0);
    reset = 1'b1;

    // Directed scenarios
    access(1'b1, 2'b10, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'd0);
    access(1'b0, 2'b00, 32'h0000_0012, 32'd0, 0, 32'd0);
    access(1'b1, 2'b01, 32'h3FFF_FFFC, 32'h0000_1234, 0, 32'd0);
    access(1'b0, 2'b10, 32'h3FFF_FFFC, 32'd0, 0, 32'd0);
    access(1'b0, 2'b10, 32'h0000_0002, 32'd0, 0, 32'd0);
    access(1'b0, 2'b10, 32'h0000_0400, 32'd0, 0, 32'd0);
    access(1'b1, 2'b10, 32'h0000_0012, 32'h1111_1111, 0, 32'd0);
    access(1'b1, 2'b10, 32'h0000_0400, 32'h2222_2222, 0, 32'd0);
    access(1'b1, 2'b11, 32'h0000_0010, 32'h3333_3333, 0, 32'd0);
    access(1'b0, 2'b10, 32'h0000_0010, 32'd0, 0, 32'd0);
    access(1'b0, 2'b10, 32'h4000_0008, 32'd0, 3, 32'h0000_00A5);
    access(1'b0, 2'b00, 32'h4000_000A, 32'd0, 1, 32'h00A5_0000);
    access(1'b1, 2'b10, 32'h4000_0010, 32'hCAFE_F00D, 0, 32'd0);
    access(1'b0, 2'b01, 32'h4000_0002, 32'd0, TMO, 32'h1234_5678);
    access(1'b1, 2'b01, 32'h4000_0006, 32'h0000_BEEF, 2, 32'd0);
    access(1'b0, 2'b10, 32'h4000_0001, 32'd0, 1, 32'd0);
    access(1'b1, 2'b10, 32'h3FFF_FF00, 32'h0BAD_F00D, 0, 32'd0);
    access(1'b0, 2'b01, 32'h3FFF_FF02, 32'd0, 0, 32'd0);
    access(1'b0, 2'b10, 32'h3FFF_FEFC, 32'd0, 0, 32'd0);
    access(1'b1, 2'b00, 32'h0000_03FF, 32'h0000_0077, 0, 32'd0);
    access(1'b0, 2'b10, 32'h0000_03FC, 32'd0, 0, 32'd0);

    // Randomized mix of RAM, stack, peripheral and unmapped accesses
    for (int n = 0; n < 150; n++) begin
      rk = int'($urandom_range(0, 5));
      rs = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      case (rk)
        0, 1, 2: ra = {20'h00000, ($urandom_range(0, 9) < 8) ? 10'($urandom_range(0, 15))
                                                            : 10'($urandom_range(250, 260)),
                       2'($urandom_range(0, 3))};
        3: ra = {20'h3FFFF, 10'($urandom_range(956, 1023)), 2'($urandom_range(0, 3))};
        4: ra = {20'h40000, 10'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
        default: ra = {20'($urandom_range(1, 20'h3FFFE)), 12'($urandom)};
      endcase
      access(1'($urandom), rs, ra, $urandom, int'($urandom_range(0, TMO + 1)), $urandom);
    end

    // Reset in the middle of a peripheral wait
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h4000_0000;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("mid_p_req_before", {31'd0, p_req}, 32'd1);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    chk("mid_p_req_after", {31'd0, p_req}, 32'd0);
    chk("mid_busy_after",  {31'd0, busy},  32'd0);
    mem_m.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    access(1'b0, 2'b10, 32'h0000_0010, 32'd0, 0, 32'd0);
    access(1'b1, 2'b10, 32'h0000_0020, 32'h5A5A_A5A5, 0, 32'd0);
    access(1'b0, 2'b01, 32'h0000_0022, 32'd0, 0, 32'd0);
    access(1'b0, 2'b10, 32'h4000_0004, 32'd0, 2, 32'h8765_4321);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/banked_data_mem.md
BANKED_DATA_MEM -- requirements
Module: banked_data_mem

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- RAM_WORDS, 256, data-bank depth in words (≤1024)
- STACK_WORDS, 64, stack-bank depth in words (≤1024), top-aligned
- PERIPH_TIMEOUT, 15, max cycles waiting for p_ack
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-low reset
- req  in  1  CPU access request, sampled when busy=0
- we  in  1  1=store, 0=load
- size  in  2  00 byte, 01 half, 10 word, 11 illegal
- addr  in  32  byte address
- wdata  in  32  store data, right-justified
- rdata  out  32  load data, right-justified, zero-extended, valid with ready
- ready  out  1  one-cycle completion pulse
- fault  out  1  valid with ready; access rejected
- busy  out  1  access in progress
- p_req  out  1  peripheral request, held until p_ack or timeout
- p_we  out  1  peripheral write
- p_addr  out  32  peripheral address (registered copy of addr)
- p_wdata  out  32  lane-aligned store data
- p_be  out  4  peripheral byte enables
- p_rdata  in  32  peripheral read data, valid with p_ack
- p_ack  in  1  peripheral completion

Function
REQ-003 Decode on addr[31:12]: 20'h00000 = RAM; 20'h3FFFF = stack; 20'h40000 = peripheral; all others unmapped.
REQ-004 Word index = addr[11:2]. RAM hit requires index < RAM_WORDS. Stack hit requires index ≥ 1024-STACK_WORDS. Out-of-range index → unmapped.
REQ-005 Alignment: word needs addr[1:0]=0; half needs addr[0]=0; size=11 is illegal. A misaligned, illegal or unmapped access → fault.
REQ-006 Byte enables: byte gives 4'b0001<<addr[1:0]; half gives 4'b0011<<addr[1:0]; word gives 4'b1111. Store data is replicated or shifted to match the lanes.
REQ-007 FSM states: IDLE, RESP, P_WAIT.
- IDLE + req, with a memory hit or a fault → RESP.
- IDLE + req, peripheral and aligned → P_WAIT.
REQ-008 Memory access: the bank is written or read at the accept edge. In RESP, ready=1 for exactly one cycle, with rdata holding the selected lanes shifted to bit 0. Latency is 1 cycle.
REQ-009 A faulting access SHALL NOT modify any storage, SHALL NOT assert p_req, and SHALL return rdata=32'h0 with ready=fault=1 in RESP.
REQ-010 P_WAIT behaviour:
- p_req=1, with p_we, p_addr, p_wdata and p_be held stable.
- A timeout counter starts at 0 and increments each cycle.
- p_ack → RESP with rdata = p_rdata lanes, fault=0.
- Counter = PERIPH_TIMEOUT without p_ack → RESP with fault=1.
- p_req drops in RESP.
REQ-011 p_ack in the same cycle the counter reaches PERIPH_TIMEOUT SHALL count as success.
REQ-012 RESP → IDLE unconditionally. busy=1 in P_WAIT and RESP. req while busy is ignored, not queued.
REQ-013 Back-to-back accesses: a new req is accepted the cycle after RESP, giving a throughput of 1 access per 2 cycles.
REQ-014 p_ack while not in P_WAIT SHALL be ignored.

Reset
REQ-015 reset=0 SHALL asynchronously:
- force IDLE;
- clear ready, fault, busy, p_req, p_we, p_be, rdata and the counter;
- clear all RAM and stack words to 0.
REQ-016 Reset during P_WAIT or RESP SHALL abort the access, with no ready pulse after release.

Structure
REQ-017 Package dmem_pkg SHALL hold the FSM state type, the size codes, the region constants (20'h00000, 20'h3FFFF, 20'h40000) and the byte-enable function.
REQ-018 Sub-module dmem_bank SHALL hold one byte-lane-enabled word array with async clear. It is parametrised by depth and base index, and instantiated once for RAM and once for stack.

Verification
REQ-019 Store word 32'hDEADBEEF to 0x00000010, then load byte at 0x00000012 → ready one cycle after each accept; load rdata=32'h000000AD; fault=0.
REQ-020 Store half 16'h1234 to 0x3FFFFFFC, then load word from 0x3FFFFFFC → rdata=32'h00001234.
REQ-021 Load word at 0x00000002, and separately load from RAM index RAM_WORDS (addr=0x00000400) → ready=fault=1, rdata=0, memory unchanged.
REQ-022 Peripheral load at 0x40000008, with p_ack after 3 cycles and p_rdata=32'h000000A5 → p_req high 3 cycles, then ready, rdata=32'hA5, fault=0.
REQ-023 Peripheral store with no p_ack → p_req held PERIPH_TIMEOUT cycles, then ready=fault=1.
REQ-024 Reset asserted mid-P_WAIT → p_req=0 immediately, no ready pulse, next access behaves normally.
